// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the Genius-style memory game.
// Sequences exp6_fluxo_dados through each round: show the newest item on
// the LEDs for SHOW_CYCLES cycles, then collect and check one player move
// per address up to the current round. The game ends on a wrong move, a
// move timeout, or after round 15 completes. Every output, including the
// 4-bit debug state code, is decoded from the state register alone.
module exp6_unidade_controle #(
    parameter int SHOW_CYCLES = 1000,
    parameter int SHOW_W      = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraCR,
    output logic       zeraE,
    output logic       contaCR,
    output logic       contaE,
    output logic       limpaRC,
    output logic       registraRC,
    output logic       zeraLeds,
    output logic       registraLeds,
    output logic       led_selector,
    output logic       contaT,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    // The encoding doubles as the 7-segment debug code, so it is fixed.
    // Codes 0xE and 0xF have no name and fall back to INICIAL.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        EXIBE       = 4'h3,
        APAGA       = 4'h4,
        ESPERA      = 4'h5,
        REGISTRA    = 4'h6,
        COMPARA     = 4'h7,
        PROXIMO     = 4'h8,
        FIM_RODADA  = 4'h9,
        PROX_RODADA = 4'hA,
        ACERTOU     = 4'hB,
        ERRO        = 4'hC,
        ESGOTADO    = 4'hD
    } estado_t;

    // Terminal count of the show counter: EXIBE lasts SHOW_CYCLES cycles.
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);

    estado_t           estado_q;
    estado_t           estado_d;
    logic [SHOW_W-1:0] show_cnt_q;
    logic [SHOW_W-1:0] show_cnt_d;

    // State and show-counter registers; reset drops straight to INICIAL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            show_cnt_q <= '0;
        end else begin
            estado_q   <= estado_d;
            show_cnt_q <= show_cnt_d;
        end
    end

    // Show counter: cleared while the item is latched, counts while lit.
    always_comb begin
        show_cnt_d = show_cnt_q;
        if (estado_q == MOSTRA) begin
            show_cnt_d = '0;
        end else if (estado_q == EXIBE) begin
            show_cnt_d = show_cnt_q + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d = PREPARA;
                end
            end
            PREPARA: estado_d = MOSTRA;
            MOSTRA:  estado_d = EXIBE;
            EXIBE: begin
                if (show_cnt_q == SHOW_LAST) begin
                    estado_d = APAGA;
                end
            end
            APAGA: estado_d = ESPERA;
            ESPERA: begin
                // A move arriving together with the timeout still counts.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (timeout) begin
                    estado_d = ESGOTADO;
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!jogada_correta) begin
                    estado_d = ERRO;
                end else if (enderecoIgualRodada) begin
                    estado_d = FIM_RODADA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: estado_d = ESPERA;
            FIM_RODADA: begin
                if (fimL) begin
                    estado_d = ACERTOU;
                end else begin
                    estado_d = PROX_RODADA;
                end
            end
            PROX_RODADA: estado_d = MOSTRA;
            // End states wait for a restart; no reset is needed.
            ACERTOU, ERRO, ESGOTADO: begin
                if (iniciar) begin
                    estado_d = PREPARA;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Moore output decode: everything low unless the state asserts it.
    always_comb begin
        zeraCR       = 1'b0;
        zeraE        = 1'b0;
        contaCR      = 1'b0;
        contaE       = 1'b0;
        limpaRC      = 1'b0;
        registraRC   = 1'b0;
        zeraLeds     = 1'b0;
        registraLeds = 1'b0;
        led_selector = 1'b0;
        contaT       = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        db_timeout   = 1'b0;
        unique case (estado_q)
            PREPARA: begin
                zeraCR   = 1'b1;
                zeraE    = 1'b1;
                limpaRC  = 1'b1;
                zeraLeds = 1'b1;
            end
            MOSTRA: begin
                registraLeds = 1'b1;
                led_selector = 1'b1;
            end
            APAGA: begin
                // Load selector=0 to blank the LEDs, rewind for the moves.
                registraLeds = 1'b1;
                zeraE        = 1'b1;
                limpaRC      = 1'b1;
            end
            ESPERA:      contaT     = 1'b1;
            REGISTRA:    registraRC = 1'b1;
            PROXIMO:     contaE     = 1'b1;
            PROX_RODADA: contaCR    = 1'b1;
            ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            ERRO: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            ESGOTADO: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Bench for exp6_unidade_controle. Each scenario is described as a game
// script (rounds, moves, idle waits, endings); the script expands into one
// entry per clock cycle holding the expected state code and the inputs for
// that cycle. Inputs the current state must ignore are randomised.
module tb_exp6_unidade_controle;

    localparam int SC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       jogada_correta = 1'b0;
    logic       enderecoIgualRodada = 1'b0;
    logic       fimL = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC;
    logic       zeraLeds, registraLeds, led_selector, contaT;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int fails  = 0;

    exp6_unidade_controle #(.SHOW_CYCLES(SC), .SHOW_W(10)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimL(fimL),
        .timeout(timeout), .zeraCR(zeraCR), .zeraE(zeraE),
        .contaCR(contaCR), .contaE(contaE), .limpaRC(limpaRC),
        .registraRC(registraRC), .zeraLeds(zeraLeds),
        .registraLeds(registraLeds), .led_selector(led_selector),
        .contaT(contaT), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] code;
        logic ini, jf, jc, eir, fl, to;
    } step_t;

    step_t script[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic [3:0] c, logic ini, logic jf, logic jc,
                                 logic eir, logic fl, logic to);
        step_t s;
        s.code = c; s.ini = ini; s.jf = jf; s.jc = jc;
        s.eir = eir; s.fl = fl; s.to = to;
        script.push_back(s);
    endfunction

    function automatic void push_noise(logic [3:0] c);
        push(c, rb(), rb(), rb(), rb(), rb(), rb());
    endfunction

    // Display of the round's new item: latch, SC lit cycles, blank.
    function automatic void add_show();
        push_noise(4'h2);
        for (int k = 0; k < SC; k++) push_noise(4'h3);
        push_noise(4'h4);
    endfunction

    // Start (or restart) from an idle/end state with code c.
    function automatic void add_start(logic [3:0] c);
        push(c, 1'b1, rb(), rb(), rb(), rb(), rb());
        push_noise(4'h1);
        add_show();
    endfunction

    // One move at address a of round r. A wrong move stops after COMPARA;
    // the caller appends the end state.
    function automatic void add_move(int r, int a, int idle, bit correct, bit force_to);
        for (int k = 0; k < idle; k++) push(4'h5, rb(), 1'b0, rb(), rb(), rb(), 1'b0);
        push(4'h5, rb(), 1'b1, rb(), rb(), rb(), force_to ? 1'b1 : rb());
        push_noise(4'h6);
        push(4'h7, rb(), rb(), correct, (a == r), rb(), rb());
        if (!correct) return;
        if (a < r) begin
            push_noise(4'h8);
        end else begin
            push(4'h9, rb(), rb(), rb(), rb(), (r == 15), rb());
            if (r == 15) return;
            push_noise(4'hA);
            add_show();
        end
    endfunction

    function automatic void add_timeout(int idle);
        for (int k = 0; k < idle; k++) push(4'h5, rb(), 1'b0, rb(), rb(), rb(), 1'b0);
        push(4'h5, rb(), 1'b0, rb(), rb(), rb(), 1'b1);
    endfunction

    function automatic void add_end(logic [3:0] c, int hold);
        for (int k = 0; k < hold; k++) push(c, 1'b0, rb(), rb(), rb(), rb(), rb());
        push(c, 1'b1, rb(), rb(), rb(), rb(), rb());
        push_noise(4'h1);
    endfunction

    // Whole game from INICIAL. kind: 0 win, 1 wrong move, 2 timeout.
    function automatic void build_game(int kind);
        int  fr = $urandom_range(0, 15);
        int  fa = $urandom_range(0, fr);
        bit  done = 0;
        add_start(4'h0);
        for (int r = 0; r < 16 && !done; r++) begin
            for (int a = 0; a <= r && !done; a++) begin
                int idle = $urandom_range(0, 3);
                if (kind != 0 && r == fr && a == fa) begin
                    if (kind == 1) begin
                        add_move(r, a, idle, 1'b0, 1'b0);
                        add_end(4'hC, $urandom_range(1, 5));
                    end else begin
                        add_timeout(idle);
                        add_end(4'hD, $urandom_range(1, 5));
                    end
                    done = 1;
                end else begin
                    add_move(r, a, idle, 1'b1, 1'b0);
                end
            end
        end
        if (!done) add_end(4'hB, $urandom_range(1, 5));
    endfunction

    // Expected {db_estado, outputs} for a state code, from the state table.
    function automatic logic [17:0] exp_vec(logic [3:0] c);
        logic zcr, ze, ccr, ce, lrc, rrc, zl, rl, ls, ct, pr, gw, pd, dt;
        {zcr, ze, ccr, ce, lrc, rrc, zl, rl, ls, ct, pr, gw, pd, dt} = '0;
        case (c)
            4'h1: begin zcr = 1; ze = 1; lrc = 1; zl = 1; end
            4'h2: begin rl = 1; ls = 1; end
            4'h4: begin rl = 1; ze = 1; lrc = 1; end
            4'h5: ct = 1;
            4'h6: rrc = 1;
            4'h8: ce = 1;
            4'hA: ccr = 1;
            4'hB: begin pr = 1; gw = 1; end
            4'hC: begin pr = 1; pd = 1; end
            4'hD: begin pr = 1; pd = 1; dt = 1; end
            default: ;
        endcase
        return {c, zcr, ze, ccr, ce, lrc, rrc, zl, rl, ls, ct, pr, gw, pd, dt};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {db_estado, zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC,
                zeraLeds, registraLeds, led_selector, contaT, pronto, ganhou,
                perdeu, db_timeout};
    endfunction

    task automatic drive(step_t s);
        iniciar = s.ini; jogada_feita = s.jf; jogada_correta = s.jc;
        enderecoIgualRodada = s.eir; fimL = s.fl; timeout = s.to;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        iniciar = 0; jogada_feita = 0; jogada_correta = 0;
        enderecoIgualRodada = 0; fimL = 0; timeout = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            iniciar = rb(); jogada_feita = rb(); timeout = rb();
            checks++;
            if (obs_vec() !== 18'h0) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: got %h expected %h", k, obs_vec(), 18'h0);
            end
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_start_show();
        script.delete();
        do_reset();
        add_start(4'h0);
        push(4'h5, 0, 0, 0, 0, 0, 0);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL start_show step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_start_show done (%0d cycles)", script.size());
    endtask

    task automatic test_round_correct();
        script.delete();
        do_reset();
        add_start(4'h0);
        add_move(0, 0, 1, 1'b1, 1'b0);
        push(4'h5, 0, 0, 0, 0, 0, 0);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL round_correct step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_round_correct done (%0d cycles)", script.size());
    endtask

    task automatic test_multi_move();
        script.delete();
        do_reset();
        add_start(4'h0);
        add_move(0, 0, 0, 1'b1, 1'b0);
        add_move(1, 0, 2, 1'b1, 1'b0);
        add_move(1, 1, 1, 1'b1, 1'b0);
        push(4'h5, 0, 0, 0, 0, 0, 0);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL multi_move step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_multi_move done (%0d cycles)", script.size());
    endtask

    task automatic test_wrong_move();
        script.delete();
        do_reset();
        add_start(4'h0);
        add_move(0, 0, 2, 1'b0, 1'b0);
        add_end(4'hC, 20);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL wrong_move step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_wrong_move done (%0d cycles)", script.size());
    endtask

    task automatic test_timeout();
        script.delete();
        do_reset();
        add_start(4'h0);
        add_timeout(3);
        add_end(4'hD, 5);
        add_show();
        add_move(0, 0, 0, 1'b1, 1'b1);
        push(4'h5, 0, 0, 0, 0, 0, 0);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL timeout step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_timeout done (%0d cycles)", script.size());
    endtask

    task automatic test_win();
        script.delete();
        do_reset();
        build_game(0);
        foreach (script[i]) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL win step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
        end
        $display("test_win done (%0d cycles)", script.size());
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 4; g++) begin
            int kind = $urandom_range(0, 2);
            script.delete();
            do_reset();
            build_game(kind);
            foreach (script[i]) begin
                @(negedge clock);
                checks++;
                if (obs_vec() !== exp_vec(script[i].code)) begin
                    fails++;
                    $display("FAIL random_game %0d step %0d: got %h expected %h", g, i, obs_vec(), exp_vec(script[i].code));
                end
                drive(script[i]);
            end
            $display("test_random_games game %0d kind %0d done (%0d cycles)", g, kind, script.size());
        end
    endtask

    task automatic test_async_reset();
        bit in_exibe = 0;
        script.delete();
        do_reset();
        add_start(4'h0);
        for (int i = 0; i < script.size() && !in_exibe; i++) begin
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec(script[i].code)) begin
                fails++;
                $display("FAIL async_reset step %0d: got %h expected %h", i, obs_vec(), exp_vec(script[i].code));
            end
            drive(script[i]);
            if (script[i].code == 4'h3) in_exibe = 1;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 18'h0) begin
            fails++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs_vec(), 18'h0);
        end
        @(negedge clock);
        iniciar = 0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (obs_vec() !== 18'h0) begin
            fails++;
            $display("FAIL async_reset_release: got %h expected %h", obs_vec(), 18'h0);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_start_show();
        test_round_correct();
        test_multi_move();
        test_wrong_move();
        test_timeout();
        test_win();
        test_random_games();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
